// File: rtl/mii_rx_fcs_check.sv
// mii_rx_fcs_check: MII receive preamble strip, byte assembly, CRC-32 check and FCS removal
module mii_rx_fcs_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rxd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic [2:0]  out_status,
  output logic [15:0] out_len,
  output logic        runt_drop
);
  localparam logic [1:0] DISCARD  = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] PREAMBLE = 2'd2;
  localparam logic [1:0] DATA     = 2'd3;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic [1:0]  state;
  logic [31:0] crc;
  logic [3:0]  low;
  logic        phase;
  logic        first;
  logic        rxer;
  logic [2:0]  fill;
  logic [15:0] cnt;
  logic [7:0]  dl [5];
  logic [7:0]  nb;
  logic        crc_bad;
  logic        rxer_now;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign nb       = {rxd, low};
  assign crc_bad  = crc != RESIDUE;
  assign rxer_now = rxer | rx_er;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= DISCARD;
      crc        <= '1;
      low        <= '0;
      phase      <= 1'b0;
      first      <= 1'b0;
      rxer       <= 1'b0;
      fill       <= '0;
      cnt        <= '0;
      for (int i = 0; i < 5; i++) dl[i] <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_good   <= 1'b0;
      out_status <= '0;
      out_len    <= '0;
      runt_drop  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      runt_drop <= 1'b0;
      case (state)
        DISCARD: if (!rx_dv) state <= IDLE;
        IDLE: if (rx_dv) state <= (rxd == 4'h5) ? PREAMBLE : DISCARD;
        PREAMBLE:
          if (!rx_dv) state <= IDLE;
          else if (rxd == 4'hD) begin
            state <= DATA;
            crc   <= '1;
            cnt   <= '0;
            fill  <= '0;
            phase <= 1'b0;
            rxer  <= 1'b0;
            first <= 1'b1;
          end else if (rxd != 4'h5) state <= DISCARD;
        DATA:
          if (rx_dv) begin
            crc   <= crc_nib(crc, rxd);
            rxer  <= rxer_now;
            phase <= ~phase;
            if (!phase) low <= rxd;
            else begin
              // always shift; once five bytes are in, dl[0] is the oldest
              for (int i = 0; i < 4; i++) dl[i] <= dl[i+1];
              dl[4] <= nb;
              fill  <= (fill == 3'd5) ? fill : fill + 3'd1;
              cnt   <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
              if (fill == 3'd5) begin
                out_valid <= 1'b1;
                out_data  <= dl[0];
                out_sof   <= first;
                first     <= 1'b0;
              end
            end
          end else begin
            state <= IDLE;
            if (fill == 3'd5) begin
              out_valid  <= 1'b1;
              out_eof    <= 1'b1;
              out_sof    <= first;
              out_data   <= dl[0];
              out_good   <= !(rxer_now | phase | crc_bad);
              out_status <= {rxer_now, phase, crc_bad};
              out_len    <= (cnt == 16'hFFFF) ? cnt : cnt - 16'd4;
            end else runt_drop <= 1'b1;
          end
        default: state <= DISCARD;
      endcase
    end
endmodule
